fpu_addsub_scheduler: RTL

//  Shares one Pre_Normalization + add/sub execute datapath between two requesters (ports 0/1).

---
 rtl/fpu_addsub_scheduler_pkg.sv | 25 ++
 rtl/fpu_addsub_scheduler_rr_arbiter2.sv | 27 ++
 rtl/fpu_addsub_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_scheduler_pkg.sv
// Shared types and constants for the add/sub scheduler that fronts the
// Pre_Normalization and execute datapath.
package fpu_addsub_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    localparam logic [31:0] QNAN_CONST = 32'h7FC0_0000;
    localparam int          REQ_FMT_W  = 32;
    localparam int          REQ_TAG_W  = 4;

    typedef struct packed {
        logic [REQ_FMT_W-1:0] a;
        logic [REQ_FMT_W-1:0] b;
        logic                 add_sub;
        logic [REQ_TAG_W-1:0] tag;
        logic                 id;
    } addsub_req_t;

endpackage

// File: rtl/fpu_addsub_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past the
// winner on every grant so a continuously requesting pair alternates.
module fpu_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic rr_ptr;

    always_comb begin
        grant_id = (valid == 2'b10) || ((valid == 2'b11) && rr_ptr);
        grant    = {2{enable}} & valid & (grant_id ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (|grant) begin
            rr_ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// Arbitrates two requesters onto one Pre_Normalization + add/sub execute path,
// bypassing execution for special operands, and returns one tagged response per request.
module fpu_addsub_scheduler
    import fpu_addsub_scheduler_pkg::*;
#(
    parameter int FORMAT_LENGTH   = REQ_FMT_W,
    parameter int EXPONENT_LENGTH = 8,
    parameter int FRACTION_LENGTH = 23,
    parameter int NORM_MAN_LENGTH = 24,
    parameter int TAG_W           = REQ_TAG_W,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [FORMAT_LENGTH-1:0]   req0_a,
    input  logic [FORMAT_LENGTH-1:0]   req0_b,
    input  logic                       req0_add_sub,
    input  logic [TAG_W-1:0]           req0_tag,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [FORMAT_LENGTH-1:0]   req1_a,
    input  logic [FORMAT_LENGTH-1:0]   req1_b,
    input  logic                       req1_add_sub,
    input  logic [TAG_W-1:0]           req1_tag,

    output logic [EXPONENT_LENGTH-1:0] pn_exp_a,
    output logic [EXPONENT_LENGTH-1:0] pn_exp_b,
    output logic [FRACTION_LENGTH-1:0] pn_fra_a,
    output logic [FRACTION_LENGTH-1:0] pn_fra_b,
    output logic                       pn_sign_a,
    output logic                       pn_sign_b,
    output logic                       pn_add_sub,
    input  logic [FORMAT_LENGTH-1:0]   pn_special_result,
    input  logic                       pn_enable,
    input  logic [EXPONENT_LENGTH-1:0] pn_exp,
    input  logic [NORM_MAN_LENGTH-1:0] pn_man_x,
    input  logic [NORM_MAN_LENGTH-1:0] pn_man_y,
    input  logic                       pn_sign,
    input  logic                       pn_sign_x,
    input  logic                       pn_sign_y,

    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [EXPONENT_LENGTH-1:0] ex_exp,
    output logic [NORM_MAN_LENGTH-1:0] ex_man_x,
    output logic [NORM_MAN_LENGTH-1:0] ex_man_y,
    output logic                       ex_sign,
    output logic                       ex_sign_x,
    output logic                       ex_sign_y,
    input  logic                       ex_done,
    input  logic [FORMAT_LENGTH-1:0]   ex_result,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [FORMAT_LENGTH-1:0]   rsp_result,
    output logic                       rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_special,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t    state;
    sched_state_t    state_nxt;
    addsub_req_t     req_q;
    logic [WD_W-1:0] watchdog;
    logic [1:0]      grant;
    logic            grant_id;
    logic            accept;
    logic            timeout_hit;

    fpu_rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    ({req1_valid, req0_valid}),
        .enable   (state == IDLE),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign accept      = |grant;
    assign timeout_hit = (watchdog == WD_W'(TIMEOUT - 1));

    // Pre_Normalization sees the latched request, so it is stable PRE..WAIT.
    assign pn_sign_a  = req_q.a[FORMAT_LENGTH-1];
    assign pn_exp_a   = req_q.a[FORMAT_LENGTH-2 -: EXPONENT_LENGTH];
    assign pn_fra_a   = req_q.a[FRACTION_LENGTH-1:0];
    assign pn_sign_b  = req_q.b[FORMAT_LENGTH-1];
    assign pn_exp_b   = req_q.b[FORMAT_LENGTH-2 -: EXPONENT_LENGTH];
    assign pn_fra_b   = req_q.b[FRACTION_LENGTH-1:0];
    assign pn_add_sub = req_q.add_sub;

    assign ex_valid  = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign rsp_id    = req_q.id;
    assign rsp_tag   = req_q.tag;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PRE;
            PRE:     state_nxt = pn_enable ? ISSUE : RESP;
            ISSUE:   if (ex_ready) state_nxt = WAIT;
            WAIT:    if (ex_done || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            watchdog    <= '0;
            ex_exp      <= '0;
            ex_man_x    <= '0;
            ex_man_y    <= '0;
            ex_sign     <= 1'b0;
            ex_sign_x   <= 1'b0;
            ex_sign_y   <= 1'b0;
            rsp_result  <= '0;
            rsp_special <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q.a       <= grant_id ? req1_a : req0_a;
                        req_q.b       <= grant_id ? req1_b : req0_b;
                        req_q.add_sub <= grant_id ? req1_add_sub : req0_add_sub;
                        req_q.tag     <= grant_id ? req1_tag : req0_tag;
                        req_q.id      <= grant_id;
                    end
                end
                PRE: begin
                    ex_exp      <= pn_exp;
                    ex_man_x    <= pn_man_x;
                    ex_man_y    <= pn_man_y;
                    ex_sign     <= pn_sign;
                    ex_sign_x   <= pn_sign_x;
                    ex_sign_y   <= pn_sign_y;
                    rsp_special <= ~pn_enable;
                    rsp_err     <= 1'b0;
                    if (!pn_enable) begin
                        rsp_result <= pn_special_result;
                    end
                end
                ISSUE: begin
                    if (ex_ready) begin
                        watchdog <= '0;
                    end
                end
                WAIT: begin
                    // A result arriving on the final watchdog cycle still counts.
                    if (ex_done) begin
                        rsp_result <= ex_result;
                    end else if (timeout_hit) begin
                        rsp_result <= QNAN_CONST;
                        rsp_err    <= 1'b1;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
